// File: rtl/axi4_lite_rr_arbiter.sv
// rtl/axi4_lite_rr_arbiter.sv - N-master to 1-slave AXI4-Lite arbiter with independent read/write grants

module axi4_lite_rr_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0,
  localparam int STRB_WIDTH   = DATA_WIDTH / 8,
  localparam int GW           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  // master-side read channels
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [1:0]                        m_rresp,
  // master-side write channels
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_awaddr,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_wstrb,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  output logic [1:0]                        m_bresp,
  // slave port
  output logic                              s_arvalid,
  input  logic                              s_arready,
  output logic [ADDR_WIDTH-1:0]             s_araddr,
  input  logic                              s_rvalid,
  output logic                              s_rready,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic [1:0]                        s_rresp,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [ADDR_WIDTH-1:0]             s_awaddr,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [STRB_WIDTH-1:0]             s_wstrb,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  input  logic [1:0]                        s_bresp,
  // observability
  output logic [1:0]                        r_state_debug,
  output logic [1:0]                        w_state_debug,
  output logic [GW-1:0]                     r_grant_debug,
  output logic [GW-1:0]                     w_grant_debug
);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2} w_state_t;

  r_state_t        r_state, r_state_next;
  w_state_t        w_state, w_state_next;
  logic [GW-1:0]   r_grant, r_grant_next, last_r, last_r_next;
  logic [GW-1:0]   w_grant, w_grant_next, last_w, last_w_next;
  logic            aw_done, aw_done_next, w_done, w_done_next;
  logic            aw_fire, w_fire;

  // Winner selection: fixed priority takes the lowest index; round-robin scans
  // last+1, last+2, ... so the most recently served master goes to the back.
  // Both loops run high-to-low so the final assignment is the preferred master.
  function automatic logic [GW-1:0] pick_winner(input logic [NUM_MASTERS-1:0] req,
                                                input logic [GW-1:0]          last);
    logic [GW-1:0] win;
    win = '0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[i]) win = GW'(i);
      end
    end else begin
      for (int i = NUM_MASTERS; i >= 1; i--) begin
        if (req[(int'(last) + i) % NUM_MASTERS]) win = GW'((int'(last) + i) % NUM_MASTERS);
      end
    end
    return win;
  endfunction

  // Response payloads are broadcast; only the granted master sees a valid.
  assign m_rdata       = s_rdata;
  assign m_rresp       = s_rresp;
  assign m_bresp       = s_bresp;
  assign r_state_debug = r_state;
  assign w_state_debug = w_state;
  assign r_grant_debug = r_grant;
  assign w_grant_debug = w_grant;

  // Read path state: FSM, grant and round-robin pointer (master 0 first after reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_grant <= '0;
      last_r  <= GW'(NUM_MASTERS - 1);
    end else begin
      r_state <= r_state_next;
      r_grant <= r_grant_next;
      last_r  <= last_r_next;
    end
  end

  // Read path next-state and routing; nothing reaches the slave while idle.
  always_comb begin
    r_state_next = r_state;
    r_grant_next = r_grant;
    last_r_next  = last_r;
    s_arvalid    = 1'b0;
    s_araddr     = '0;
    s_rready     = 1'b0;
    m_arready    = '0;
    m_rvalid     = '0;
    case (r_state)
      R_IDLE: begin
        if (|m_arvalid) begin
          r_grant_next = pick_winner(m_arvalid, last_r);
          r_state_next = R_ADDR;
        end
      end
      R_ADDR: begin
        s_arvalid          = m_arvalid[r_grant];
        s_araddr           = m_araddr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
        m_arready[r_grant] = s_arready;
        if (m_arvalid[r_grant] && s_arready) r_state_next = R_DATA;
      end
      R_DATA: begin
        m_rvalid[r_grant] = s_rvalid;
        s_rready          = m_rready[r_grant];
        if (s_rvalid && m_rready[r_grant]) begin
          r_state_next = R_IDLE;
          last_r_next  = r_grant;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Write path state: FSM, grant, pointer and the sticky AW/W completion flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_grant <= '0;
      last_w  <= GW'(NUM_MASTERS - 1);
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_next;
      w_grant <= w_grant_next;
      last_w  <= last_w_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
    end
  end

  // Write path next-state and routing; AW and W proceed independently and each
  // is silenced once it has handshaken so the slave never sees a second beat.
  always_comb begin
    w_state_next = w_state;
    w_grant_next = w_grant;
    last_w_next  = last_w;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    aw_fire      = 1'b0;
    w_fire       = 1'b0;
    s_awvalid    = 1'b0;
    s_awaddr     = '0;
    s_wvalid     = 1'b0;
    s_wdata      = '0;
    s_wstrb      = '0;
    s_bready     = 1'b0;
    m_awready    = '0;
    m_wready     = '0;
    m_bvalid     = '0;
    case (w_state)
      W_IDLE: begin
        if (|m_awvalid) begin
          w_grant_next = pick_winner(m_awvalid, last_w);
          w_state_next = W_ADDR;
        end
      end
      W_ADDR: begin
        s_awvalid          = m_awvalid[w_grant] & ~aw_done;
        s_awaddr           = m_awaddr[w_grant*ADDR_WIDTH +: ADDR_WIDTH];
        m_awready[w_grant] = s_awready & ~aw_done;
        s_wvalid           = m_wvalid[w_grant] & ~w_done;
        s_wdata            = m_wdata[w_grant*DATA_WIDTH +: DATA_WIDTH];
        s_wstrb            = m_wstrb[w_grant*STRB_WIDTH +: STRB_WIDTH];
        m_wready[w_grant]  = s_wready & ~w_done;
        aw_fire            = s_awvalid & s_awready;
        w_fire             = s_wvalid & s_wready;
        if ((aw_done || aw_fire) && (w_done || w_fire)) begin
          aw_done_next = 1'b0;
          w_done_next  = 1'b0;
          w_state_next = W_RESP;
        end else begin
          aw_done_next = aw_done | aw_fire;
          w_done_next  = w_done | w_fire;
        end
      end
      W_RESP: begin
        m_bvalid[w_grant] = s_bvalid;
        s_bready          = m_bready[w_grant];
        if (s_bvalid && m_bready[w_grant]) begin
          w_state_next = W_IDLE;
          last_w_next  = w_grant;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// tb/tb_axi4_lite_rr_arbiter.sv - scoreboard bench for axi4_lite_rr_arbiter

module tb_axi4_lite_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;

  // ---------------- DUT A: 3 masters, round-robin ----------------
  logic [2:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [2:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [95:0] m_araddr, m_awaddr, m_wdata;
  logic [11:0] m_wstrb;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_rresp, s_bresp;
  logic [1:0]  r_state_debug, w_state_debug, r_grant_debug, w_grant_debug;

  axi4_lite_rr_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .r_state_debug(r_state_debug), .w_state_debug(w_state_debug),
    .r_grant_debug(r_grant_debug), .w_grant_debug(w_grant_debug)
  );

  // ---------------- DUT B: 3 masters, fixed priority, read-only use ----------------
  logic [2:0]  b_arvalid, b_arready, b_rvalid, b_awready, b_wready, b_bvalid;
  logic [95:0] b_araddr;
  logic [31:0] b_rdata, bs_araddr, bs_awaddr, bs_wdata;
  logic [1:0]  b_rresp, b_bresp;
  logic        bs_arvalid, bs_rvalid, bs_rready, bs_awvalid, bs_wvalid, bs_bready;
  logic [3:0]  bs_wstrb;
  logic [1:0]  b_rsd, b_wsd, b_rgd, b_wgd;
  logic        b_pend;

  axi4_lite_rr_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .PRIORITY_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m_arvalid(b_arvalid), .m_arready(b_arready), .m_araddr(b_araddr),
    .m_rvalid(b_rvalid), .m_rready(3'b111), .m_rdata(b_rdata), .m_rresp(b_rresp),
    .m_awvalid(3'b000), .m_awready(b_awready), .m_awaddr(96'd0),
    .m_wvalid(3'b000), .m_wready(b_wready), .m_wdata(96'd0), .m_wstrb(12'd0),
    .m_bvalid(b_bvalid), .m_bready(3'b111), .m_bresp(b_bresp),
    .s_arvalid(bs_arvalid), .s_arready(1'b1), .s_araddr(bs_araddr),
    .s_rvalid(bs_rvalid), .s_rready(bs_rready), .s_rdata(32'h0), .s_rresp(2'b00),
    .s_awvalid(bs_awvalid), .s_awready(1'b0), .s_awaddr(bs_awaddr),
    .s_wvalid(bs_wvalid), .s_wready(1'b0), .s_wdata(bs_wdata), .s_wstrb(bs_wstrb),
    .s_bvalid(1'b0), .s_bready(bs_bready), .s_bresp(2'b00),
    .r_state_debug(b_rsd), .w_state_debug(b_wsd),
    .r_grant_debug(b_rgd), .w_grant_debug(b_wgd)
  );

  always @(posedge clk) begin
    if (!rst) b_pend <= 1'b0;
    else if (bs_arvalid) b_pend <= 1'b1;
    else if (bs_rvalid && bs_rready) b_pend <= 1'b0;
  end
  assign bs_rvalid = b_pend;

  // ---------------- slave model for DUT A ----------------
  logic        sl_arready, sl_awready, sl_wready, sl_rhold;
  logic        rd_pend, aw_got, w_got, wb_pend;
  logic [31:0] rd_addr, wr_addr;

  assign s_arready = sl_arready;
  assign s_awready = sl_awready;
  assign s_wready  = sl_wready;
  assign s_rvalid  = rd_pend & ~sl_rhold;
  assign s_rdata   = (rd_addr == 32'h8000_0010) ? 32'hDEAD_BEEF : ~rd_addr;
  assign s_rresp   = rd_addr[5:4];
  assign s_bvalid  = wb_pend;
  assign s_bresp   = wr_addr[5:4];

  always @(posedge clk) begin
    if (!rst) rd_pend <= 1'b0;
    else if (s_arvalid && s_arready) begin
      rd_pend <= 1'b1;
      rd_addr <= s_araddr;
    end else if (s_rvalid && s_rready) rd_pend <= 1'b0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      aw_got <= 1'b0; w_got <= 1'b0; wb_pend <= 1'b0;
    end else begin
      if (s_bvalid && s_bready) wb_pend <= 1'b0;
      if (s_awvalid && s_awready) begin
        aw_got  <= 1'b1;
        wr_addr <= s_awaddr;
      end
      if (s_wvalid && s_wready) w_got <= 1'b1;
      if ((aw_got || (s_awvalid && s_awready)) && (w_got || (s_wvalid && s_wready))) begin
        wb_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [1:0] g; logic [31:0] addr; } ar_t;
  typedef struct packed { logic [2:0] vec; logic [31:0] data; logic [1:0] resp; } r_t;
  typedef struct packed { logic [2:0] vec; logic [1:0] resp; } b_t;

  ar_t         exp_ar[$];
  r_t          exp_r[$];
  b_t          exp_b[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [1:0]  exp_gb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  ar_t         e_ar;
  r_t          e_r;
  b_t          e_b;
  logic [31:0] e_aw;
  logic [35:0] e_w;
  logic [1:0]  e_gb;

  // Monitor: handshakes are stable at the falling edge and commit on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (r_state_debug != 2'd0 && w_state_debug != 2'd0) ov_cnt++;
      if (s_arvalid && s_arready) begin
        if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
        else begin
          e_ar = exp_ar.pop_front();
          check("ar_grant", 64'(r_grant_debug), 64'(e_ar.g));
          check("ar_addr", 64'(s_araddr), 64'(e_ar.addr));
        end
      end
      if (|(m_rvalid & m_rready)) begin
        if (exp_r.size() == 0) check("r_unexpected", 64'(m_rvalid), 0);
        else begin
          e_r = exp_r.pop_front();
          check("r_route", 64'(m_rvalid), 64'(e_r.vec));
          check("r_data", 64'(m_rdata), 64'(e_r.data));
          check("r_resp", 64'(m_rresp), 64'(e_r.resp));
        end
      end
      if (|(m_bvalid & m_bready)) begin
        if (exp_b.size() == 0) check("b_unexpected", 64'(m_bvalid), 0);
        else begin
          e_b = exp_b.pop_front();
          check("b_route", 64'(m_bvalid), 64'(e_b.vec));
          check("b_resp", 64'(m_bresp), 64'(e_b.resp));
        end
      end
      if (s_awvalid && s_awready) begin
        if (exp_aw.size() == 0) check("aw_unexpected", 64'(s_awaddr), 0);
        else begin
          e_aw = exp_aw.pop_front();
          check("aw_addr", 64'(s_awaddr), 64'(e_aw));
        end
      end
      if (s_wvalid && s_wready) begin
        if (exp_w.size() == 0) check("w_unexpected", 64'({s_wdata, s_wstrb}), 0);
        else begin
          e_w = exp_w.pop_front();
          check("w_data_strb", 64'({s_wdata, s_wstrb}), 64'(e_w));
        end
      end
      if (bs_arvalid) begin
        if (exp_gb.size() == 0) check("fp_unexpected", 64'(b_rgd), 0);
        else begin
          e_gb = exp_gb.pop_front();
          check("fp_grant", 64'(b_rgd), 64'(e_gb));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_read(input int i, input logic [31:0] addr, input logic [31:0] data);
    exp_ar.push_back('{g: 2'(i), addr: addr});
    exp_r.push_back('{vec: 3'(1 << i), data: data, resp: addr[5:4]});
  endtask

  // d selects the bench instance: 0 = round-robin DUT, 1 = fixed-priority DUT
  task automatic rd(input int d, input int i, input logic [31:0] addr);
    int n;
    n = 0;
    if (d == 0) begin m_araddr[i*32 +: 32] = addr; m_arvalid[i] = 1'b1; end
    else begin b_araddr[i*32 +: 32] = addr; b_arvalid[i] = 1'b1; end
    do begin
      @(negedge clk);
      n++;
    end while (!((d == 0) ? m_arready[i] : b_arready[i]) && n < 200);
    if (n >= 200) check("ar_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (d == 0) m_arvalid[i] = 1'b0;
    else b_arvalid[i] = 1'b0;
  endtask

  task automatic wr(input int i, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int   n;
    logic a_ok, w_ok;
    n = 0;
    m_awaddr[i*32 +: 32] = addr;
    m_wdata[i*32 +: 32]  = data;
    m_wstrb[i*4 +: 4]    = strb;
    m_awvalid[i] = 1'b1;
    m_wvalid[i]  = 1'b1;
    while ((m_awvalid[i] || m_wvalid[i]) && n < 200) begin
      @(negedge clk);
      n++;
      a_ok = m_awvalid[i] & m_awready[i];
      w_ok = m_wvalid[i] & m_wready[i];
      @(posedge clk);
      #1;
      if (a_ok) m_awvalid[i] = 1'b0;
      if (w_ok) m_wvalid[i]  = 1'b0;
    end
    if (n >= 200) check("wr_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_ar.size() + exp_r.size() + exp_b.size() + exp_aw.size() + exp_w.size() + exp_gb.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ov_before;
    rst = 1'b0;
    m_arvalid = '0; m_araddr = '0; m_rready = '1;
    m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_bready = '1;
    b_arvalid = '0; b_araddr = '0;
    sl_arready = 1'b1; sl_awready = 1'b1; sl_wready = 1'b1; sl_rhold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_states", 64'({r_state_debug, w_state_debug}), 0);
    check("rst_grants", 64'({r_grant_debug, w_grant_debug}), 0);
    check("rst_s_ctrl", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}), 0);
    check("rst_m_ctrl", 64'({m_arready, m_rvalid, m_awready, m_wready, m_bvalid}), 0);
    @(posedge clk); #1 rst = 1'b1;

    // single read by master 1, arbitration costs exactly one idle cycle
    @(posedge clk); #1;
    push_read(1, 32'h8000_0010, 32'hDEAD_BEEF);
    m_araddr[32 +: 32] = 32'h8000_0010;
    m_arvalid[1] = 1'b1;
    @(negedge clk);
    check("t1_idle_arvalid", 64'(s_arvalid), 0);
    check("t1_idle_state", 64'(r_state_debug), 0);
    @(negedge clk);
    check("t1_addr_arvalid", 64'(s_arvalid), 1);
    check("t1_grant", 64'(r_grant_debug), 1);
    @(posedge clk); #1 m_arvalid[1] = 1'b0;
    drain();

    // round-robin with all three requesting; last served was master 1
    push_read(2, 32'h1000_0200, ~32'h1000_0200);
    push_read(0, 32'h1000_0000, ~32'h1000_0000);
    push_read(1, 32'h1000_0100, ~32'h1000_0100);
    push_read(2, 32'h1000_0220, ~32'h1000_0220);
    push_read(0, 32'h1000_0020, ~32'h1000_0020);
    push_read(1, 32'h1000_0120, ~32'h1000_0120);
    @(posedge clk); #1;
    fork
      begin rd(0, 0, 32'h1000_0000); rd(0, 0, 32'h1000_0020); end
      begin rd(0, 1, 32'h1000_0100); rd(0, 1, 32'h1000_0120); end
      begin rd(0, 2, 32'h1000_0200); rd(0, 2, 32'h1000_0220); end
    join
    drain();

    // concurrent write by master 0 and read by master 1
    ov_before = ov_cnt;
    push_read(1, 32'h8000_0020, 32'h7FFF_FFDF);
    exp_aw.push_back(32'h8000_0100);
    exp_w.push_back({32'h1234_5678, 4'hF});
    exp_b.push_back('{vec: 3'b001, resp: 2'd0});
    @(posedge clk); #1;
    fork
      wr(0, 32'h8000_0100, 32'h1234_5678, 4'hF);
      rd(0, 1, 32'h8000_0020);
    join
    drain();
    check("t4_overlap", 64'(ov_cnt > ov_before), 1);

    // W handshakes two cycles before AW; master 2 keeps wvalid high throughout
    @(posedge clk); #1;
    sl_awready = 1'b0;
    exp_aw.push_back(32'h8000_0230);
    exp_w.push_back({32'hCAFE_F00D, 4'b0101});
    exp_b.push_back('{vec: 3'b100, resp: 2'd3});
    m_awaddr[64 +: 32] = 32'h8000_0230;
    m_wdata[64 +: 32]  = 32'hCAFE_F00D;
    m_wstrb[8 +: 4]    = 4'b0101;
    m_awvalid[2] = 1'b1;
    m_wvalid[2]  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5_waddr_state", 64'(w_state_debug), 1);
    check("t5_wgrant", 64'(w_grant_debug), 2);
    check("t5_wvalid_first", 64'(s_wvalid), 1);
    @(negedge clk);
    check("t5_wvalid_masked1", 64'({s_wvalid, m_wready[2]}), 0);
    check("t5_hold_waddr1", 64'(w_state_debug), 1);
    @(posedge clk); #1 sl_awready = 1'b1;
    @(negedge clk);
    check("t5_wvalid_masked2", 64'({s_wvalid, m_wready[2]}), 0);
    check("t5_hold_waddr2", 64'(w_state_debug), 1);
    check("t5_awvalid", 64'(s_awvalid), 1);
    @(posedge clk); #1;
    m_awvalid[2] = 1'b0;
    m_wvalid[2]  = 1'b0;
    @(negedge clk);
    check("t5_wresp_state", 64'(w_state_debug), 2);
    drain();

    // reset in the middle of R_DATA, then all three request after release
    sl_rhold = 1'b1;
    exp_ar.push_back('{g: 2'd2, addr: 32'h8000_0040});
    @(posedge clk); #1;
    rd(0, 2, 32'h8000_0040);
    @(negedge clk);
    check("t6_rdata_state", 64'(r_state_debug), 2);
    check("t6_rready_before", 64'(s_rready), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_rready", 64'(s_rready), 0);
    check("t6_async_state", 64'(r_state_debug), 0);
    check("t6_async_grant", 64'(r_grant_debug), 0);
    @(posedge clk); #1 sl_rhold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    push_read(0, 32'h2000_0000, ~32'h2000_0000);
    push_read(1, 32'h2000_0010, ~32'h2000_0010);
    push_read(2, 32'h2000_0020, ~32'h2000_0020);
    @(posedge clk); #1;
    fork
      rd(0, 0, 32'h2000_0000);
      rd(0, 1, 32'h2000_0010);
      rd(0, 2, 32'h2000_0020);
    join
    drain();

    // fixed priority: master 0 keeps winning while it requests; master 2 waits
    for (int k = 0; k < 4; k++) exp_gb.push_back(2'd0);
    exp_gb.push_back(2'd2);
    @(posedge clk); #1;
    fork
      begin for (int k = 0; k < 4; k++) rd(1, 0, 32'h3000_0000 + 32'(k)); end
      rd(1, 2, 32'h3000_0200);
    join
    drain();

    check("left_ar", 64'(exp_ar.size()), 0);
    check("left_r", 64'(exp_r.size()), 0);
    check("left_b", 64'(exp_b.size()), 0);
    check("left_aw", 64'(exp_aw.size()), 0);
    check("left_w", 64'(exp_w.size()), 0);
    check("left_fp", 64'(exp_gb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
